param_register_file: RTL and testbench
======================================

# param_register_file

Parametrised successor to the CPU's 64×32 register file: configurable width and depth, two registered read ports, one write port with write-to-read bypass, an optional hard-wired zero register, and a hardware clear sequencer. It sits between the decode stage (read addresses) and the writeback stage (write port). A clear sequencer zeroes every entry after reset or on request, so the datapath no longer relies on simulation-only initial blocks.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 6, address width; depth DEPTH = 2**ADDR_W
- ZERO_REG, 1, when 1 entry 0 always reads 0 and ignores writes
- clock  in  1  single clock, all logic on rising edge
- reset_n  in  1  synchronous, active-low reset
- clear  in  1  request full re-clear; sampled only in RUN
- rs_addr  in  ADDR_W  read port A address
- rt_addr  in  ADDR_W  read port B address
- rd_addr  in  ADDR_W  write address
- write  in  1  write enable
- data_in  in  DATA_W  write data
- rs  out  DATA_W  read port A data, registered
- rt  out  DATA_W  read port B data, registered
- ready  out  1  high when in RUN and accepting writes

## Operation
- Two states: CLEAR, RUN.
- Reset (reset_n=0 at a rising edge): state←CLEAR, clr_ptr←0, rs←0, rt←0, ready←0.
- CLEAR: each cycle writes 0 to data[clr_ptr], then clr_ptr increments. When clr_ptr==DEPTH-1, that entry is written and state←RUN on the same edge. ready stays 0 throughout.
- CLEAR: write is ignored; rs and rt register 0 every cycle.
- RUN: ready=1. If write=1, data[rd_addr]←data_in at the edge, except rd_addr==0 when ZERO_REG=1.
- RUN reads: rs←data[rs_addr] and rt←data[rt_addr] at every edge, regardless of whether the address changed.
- Bypass: in RUN, if write=1 and rd_addr==rs_addr, rs←data_in; the same applies independently to rt. Bypass is suppressed for address 0 when ZERO_REG=1, which returns 0.
- Both read ports may address the same entry. Both may bypass in the same cycle.
- clear=1 in RUN: state←CLEAR and clr_ptr←0 at that edge. A write presented in the same cycle is dropped. ready falls on the next cycle.
- clear while already in CLEAR: ignored; the sweep does not restart.
- reset_n=0 mid-sweep: the sweep restarts at 0. Reset has priority over clear and write.
- clr_ptr is ADDR_W bits. The terminal test is an explicit compare with DEPTH-1, not reliance on wrap-around.

## Timing
- Read latency: 1 cycle. An address presented in cycle N gives data valid after edge N+1.
- Write-to-read: a write at edge N is visible through bypass in the same cycle and through storage from cycle N+1 onward.
- Clear duration: exactly DEPTH cycles from the first CLEAR cycle to the first RUN cycle. With default parameters ready rises 64 cycles after reset_n is released.
- No combinational path from any input to any output.

## Structure
- Package regfile_pkg holds:
  - the state enum {CLEAR, RUN}
  - default localparams for DATA_W and ADDR_W, shared with the decode and writeback stages
- Sub-module regfile_clear_seq: the state register, clr_ptr, the terminal-count compare and ready. Its outputs are clr_we, clr_addr and ready.
- Top level muxes the clear write over the user write and holds the storage array and the output registers.

## Test plan
- Reset with defaults: release reset_n, hold write=1 with data_in=0xDEAD -> ready=0 for 64 cycles, no entry written, rs=rt=0; ready=1 on cycle 65.
- After ready: write 0x14 to r3, then read rs_addr=3 and rt_addr=3 -> both return 0x14 one cycle later.
- Bypass: same cycle write=1, rd_addr=5, data_in=0xA5A5A5A5, rs_addr=5 -> rs=0xA5A5A5A5 next cycle; rt_addr=6 unaffected.
- ZERO_REG=1: write 0xFFFFFFFF to r0, read r0 on both ports, including the bypass case -> 0.
- Mid-operation clear: fill r1..r63 with their own indices, pulse clear together with a write to r7 -> ready low 64 cycles, afterwards every register reads 0 and r7 was not written.
- Reset mid-sweep at clr_ptr=30, plus ADDR_W=3 / DATA_W=16 configuration -> sweep restarts, ready after exactly DEPTH cycles (8 for ADDR_W=3).

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared definitions for the parametrised register file and its neighbours.
// Holds the sequencer state encoding and the default geometry that the
// decode and writeback stages size their address/data buses from.
package regfile_pkg;

  typedef enum logic {
    CLEAR,
    RUN
  } state_t;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_ADDR_W = 6;

endpackage

// File: rtl/param_register_file_if.sv
// Bus bundle between decode/writeback and the register file.
//   slave  : register file side (takes addresses/write data, returns rs/rt/ready)
//   master : pipeline side
interface param_register_file_if
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W
);

  logic              clear;
  logic [ADDR_W-1:0] rs_addr;
  logic [ADDR_W-1:0] rt_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic              write;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] rs;
  logic [DATA_W-1:0] rt;
  logic              ready;

  modport slave (
    input  clear, rs_addr, rt_addr, rd_addr, write, data_in,
    output rs, rt, ready
  );

  modport master (
    output clear, rs_addr, rt_addr, rd_addr, write, data_in,
    input  rs, rt, ready
  );

endinterface

// File: rtl/regfile_clear_seq.sv
// Clear sequencer: after reset or a clear request, walks clr_ptr over every
// entry issuing a zero write, then enters RUN.
//   clock, reset_n : clock and synchronous active-low reset
//   clear          : re-clear request, honoured only in RUN
//   clr_we         : sweep write strobe (high for every CLEAR cycle)
//   clr_addr       : entry being zeroed
//   ready          : high in RUN
module regfile_clear_seq
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              clear,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr,
  output logic              ready
);

  localparam int unsigned       DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);

  state_t            state, state_nx;
  logic [ADDR_W-1:0] clr_ptr, clr_ptr_nx;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state   <= CLEAR;
      clr_ptr <= '0;
    end else begin
      state   <= state_nx;
      clr_ptr <= clr_ptr_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    clr_ptr_nx = clr_ptr;
    clr_we     = 1'b0;
    case (state)
      CLEAR: begin
        clr_we = 1'b1;
        // Terminal entry is detected explicitly; pointer is parked at 0.
        if (clr_ptr == LAST) begin
          state_nx   = RUN;
          clr_ptr_nx = '0;
        end else begin
          clr_ptr_nx = clr_ptr + 1'b1;
        end
      end
      RUN: begin
        if (clear) begin
          state_nx   = CLEAR;
          clr_ptr_nx = '0;
        end
      end
    endcase
  end

  assign clr_addr = clr_ptr;
  assign ready    = (state == RUN);

endmodule

// File: rtl/param_register_file.sv
// Parametrised register file: two registered read ports, one write port
// with write-to-read bypass, optional hard-wired zero entry, and a hardware
// clear sweep after reset or on request.
//   clock, reset_n : clock and synchronous active-low reset
//   bus (slave)    : clear, rs_addr, rt_addr, rd_addr, write, data_in in;
//                    rs, rt (registered read data), ready out
module param_register_file
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  param_register_file_if.slave  bus
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] data [DEPTH];

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              ready;

  regfile_clear_seq #(
    .ADDR_W (ADDR_W)
  ) u_clear_seq (
    .clock    (clock),
    .reset_n  (reset_n),
    .clear    (bus.clear),
    .clr_we   (clr_we),
    .clr_addr (clr_addr),
    .ready    (ready)
  );

  // A write arriving with a clear request is dropped, including its bypass.
  logic user_we;
  logic zero_dst;
  logic store_we;
  logic [ADDR_W-1:0] store_addr;
  logic [DATA_W-1:0] store_data;

  assign user_we    = ready & bus.write & ~bus.clear;
  assign zero_dst   = ZERO_REG && (bus.rd_addr == '0);
  assign store_we   = reset_n & (clr_we | (user_we & ~zero_dst));
  assign store_addr = clr_we ? clr_addr : bus.rd_addr;
  assign store_data = clr_we ? '0 : bus.data_in;

  always_ff @(posedge clock) begin
    if (store_we) begin
      data[store_addr] <= store_data;
    end
  end

  logic [DATA_W-1:0] rs_nx, rt_nx;

  always_comb begin
    rs_nx = '0;
    rt_nx = '0;
    if (ready) begin
      if (ZERO_REG && bus.rs_addr == '0)
        rs_nx = '0;
      else if (user_we && bus.rd_addr == bus.rs_addr)
        rs_nx = bus.data_in;
      else
        rs_nx = data[bus.rs_addr];

      if (ZERO_REG && bus.rt_addr == '0)
        rt_nx = '0;
      else if (user_we && bus.rd_addr == bus.rt_addr)
        rt_nx = bus.data_in;
      else
        rt_nx = data[bus.rt_addr];
    end
  end

  logic [DATA_W-1:0] rs_q, rt_q;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rs_q <= '0;
      rt_q <= '0;
    end else begin
      rs_q <= rs_nx;
      rt_q <= rt_nx;
    end
  end

  assign bus.rs    = rs_q;
  assign bus.rt    = rt_q;
  assign bus.ready = ready;

endmodule

// File: tb/tb_param_register_file.sv
// Bench for param_register_file: default instance (64x32, zero register)
// and a small instance (8x16, no zero register) checked against a
// countdown-based behavioural model.
module tb_param_register_file;

  logic clock = 1'b0;
  logic rst_a = 1'b0;
  logic rst_b = 1'b0;
  always #5 clock = ~clock;

  param_register_file_if #(.DATA_W(32), .ADDR_W(6)) ifa ();
  param_register_file_if #(.DATA_W(16), .ADDR_W(3)) ifb ();

  param_register_file #(.DATA_W(32), .ADDR_W(6), .ZERO_REG(1'b1)) dut_a (
    .clock   (clock),
    .reset_n (rst_a),
    .bus     (ifa)
  );

  param_register_file #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1'b0)) dut_b (
    .clock   (clock),
    .reset_n (rst_b),
    .bus     (ifb)
  );

  int checks = 0;
  int failures = 0;

  // Model: busy = clear cycles still to go; ready when it reaches 0.
  logic [31:0] mem_a [64];
  logic [15:0] mem_b [8];
  int          busy_a = 64;
  int          busy_b = 8;
  logic [31:0] exp_rs_a = '0, exp_rt_a = '0;
  logic [15:0] exp_rs_b = '0, exp_rt_b = '0;

  function automatic logic [31:0] read_a(input logic [5:0] addr, input logic wr,
                                         input logic clr, input logic [5:0] rd,
                                         input logic [31:0] din);
    if (addr == 6'd0) return 32'd0;
    if (wr && !clr && rd == addr) return din;
    return mem_a[addr];
  endfunction

  function automatic logic [15:0] read_b(input logic [2:0] addr, input logic wr,
                                         input logic clr, input logic [2:0] rd,
                                         input logic [15:0] din);
    if (wr && !clr && rd == addr) return din;
    return mem_b[addr];
  endfunction

  task automatic step_a();
    if (!rst_a) begin
      busy_a = 64; exp_rs_a = '0; exp_rt_a = '0;
    end else if (busy_a > 0) begin
      mem_a[64 - busy_a] = '0;
      busy_a--;
      exp_rs_a = '0; exp_rt_a = '0;
    end else begin
      exp_rs_a = read_a(ifa.rs_addr, ifa.write, ifa.clear, ifa.rd_addr, ifa.data_in);
      exp_rt_a = read_a(ifa.rt_addr, ifa.write, ifa.clear, ifa.rd_addr, ifa.data_in);
      if (ifa.clear) busy_a = 64;
      else if (ifa.write && ifa.rd_addr != 6'd0) mem_a[ifa.rd_addr] = ifa.data_in;
    end
  endtask

  task automatic step_b();
    if (!rst_b) begin
      busy_b = 8; exp_rs_b = '0; exp_rt_b = '0;
    end else if (busy_b > 0) begin
      mem_b[8 - busy_b] = '0;
      busy_b--;
      exp_rs_b = '0; exp_rt_b = '0;
    end else begin
      exp_rs_b = read_b(ifb.rs_addr, ifb.write, ifb.clear, ifb.rd_addr, ifb.data_in);
      exp_rt_b = read_b(ifb.rt_addr, ifb.write, ifb.clear, ifb.rd_addr, ifb.data_in);
      if (ifb.clear) busy_b = 8;
      else if (ifb.write) mem_b[ifb.rd_addr] = ifb.data_in;
    end
  endtask

  task automatic tick();
    @(posedge clock);
    step_a();
    step_b();
    #1;
  endtask

  task automatic idle_inputs();
    ifa.clear = 0; ifa.write = 0; ifa.rd_addr = '0; ifa.rs_addr = '0; ifa.rt_addr = '0; ifa.data_in = '0;
    ifb.clear = 0; ifb.write = 0; ifb.rd_addr = '0; ifb.rs_addr = '0; ifb.rt_addr = '0; ifb.data_in = '0;
  endtask

  task automatic test_reset();
    int first_a, first_b;
    idle_inputs();
    rst_a = 0; rst_b = 0;
    tick(); tick();
    checks++;
    if (ifa.rs !== 32'd0 || ifa.rt !== 32'd0 || ifa.ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_a: rs=%h rt=%h ready=%b expected 0 0 0", ifa.rs, ifa.rt, ifa.ready);
    end
    checks++;
    if (ifb.rs !== 16'd0 || ifb.rt !== 16'd0 || ifb.ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_b: rs=%h rt=%h ready=%b expected 0 0 0", ifb.rs, ifb.rt, ifb.ready);
    end
    // Writes held active during the sweep must be ignored.
    ifa.write = 1; ifa.data_in = 32'hDEAD;
    rst_a = 1; rst_b = 1;
    first_a = -1; first_b = -1;
    for (int k = 1; k <= 64; k++) begin
      ifa.rd_addr = 6'($urandom_range(0, 63));
      ifa.rs_addr = ifa.rd_addr;
      ifa.rt_addr = 6'($urandom_range(0, 63));
      tick();
      if (first_a < 0 && ifa.ready === 1'b1) first_a = k;
      if (first_b < 0 && ifb.ready === 1'b1) first_b = k;
      checks++;
      if (ifa.ready !== (busy_a == 0) || ifa.rs !== exp_rs_a || ifa.rt !== exp_rt_a) begin
        failures++;
        $display("FAIL sweep_a k=%0d: ready=%b rs=%h rt=%h expected %b %h %h",
                 k, ifa.ready, ifa.rs, ifa.rt, busy_a == 0, exp_rs_a, exp_rt_a);
      end
    end
    ifa.write = 0;
    checks++;
    if (first_a != 64) begin
      failures++;
      $display("FAIL ready_latency_a: got %0d expected 64", first_a);
    end
    checks++;
    if (first_b != 8) begin
      failures++;
      $display("FAIL ready_latency_b: got %0d expected 8", first_b);
    end
    for (int i = 0; i < 64; i++) begin
      ifa.rs_addr = 6'(i); ifa.rt_addr = 6'(63 - i);
      tick();
      checks++;
      if (ifa.rs !== 32'd0 || ifa.rt !== 32'd0) begin
        failures++;
        $display("FAIL cleared_a r%0d: rs=%h rt=%h expected 0", i, ifa.rs, ifa.rt);
      end
    end
  endtask

  task automatic test_write_read();
    ifa.write = 1; ifa.rd_addr = 6'd3; ifa.data_in = 32'h14;
    ifa.rs_addr = 6'd10; ifa.rt_addr = 6'd11;
    tick();
    ifa.write = 0; ifa.rs_addr = 6'd3; ifa.rt_addr = 6'd3;
    tick();
    checks++;
    if (ifa.rs !== 32'h14 || ifa.rt !== 32'h14) begin
      failures++;
      $display("FAIL write_read r3: rs=%h rt=%h expected 00000014", ifa.rs, ifa.rt);
    end
  endtask

  task automatic test_bypass();
    ifa.write = 1; ifa.rd_addr = 6'd5; ifa.data_in = 32'hA5A5A5A5;
    ifa.rs_addr = 6'd5; ifa.rt_addr = 6'd6;
    tick();
    ifa.write = 0;
    checks++;
    if (ifa.rs !== 32'hA5A5A5A5 || ifa.rt !== exp_rt_a) begin
      failures++;
      $display("FAIL bypass_rs: rs=%h rt=%h expected a5a5a5a5 %h", ifa.rs, ifa.rt, exp_rt_a);
    end
    // Both ports bypassing the same write.
    ifa.write = 1; ifa.rd_addr = 6'd9; ifa.data_in = 32'h1234_5678;
    ifa.rs_addr = 6'd9; ifa.rt_addr = 6'd9;
    tick();
    ifa.write = 0;
    checks++;
    if (ifa.rs !== 32'h1234_5678 || ifa.rt !== 32'h1234_5678) begin
      failures++;
      $display("FAIL bypass_both: rs=%h rt=%h expected 12345678", ifa.rs, ifa.rt);
    end
    ifa.rs_addr = 6'd5; ifa.rt_addr = 6'd9;
    tick();
    checks++;
    if (ifa.rs !== 32'hA5A5A5A5 || ifa.rt !== 32'h1234_5678) begin
      failures++;
      $display("FAIL stored_after_bypass: rs=%h rt=%h expected a5a5a5a5 12345678", ifa.rs, ifa.rt);
    end
  endtask

  task automatic test_zero_reg();
    ifa.write = 1; ifa.rd_addr = 6'd0; ifa.data_in = 32'hFFFF_FFFF;
    ifa.rs_addr = 6'd0; ifa.rt_addr = 6'd0;
    tick();
    ifa.write = 0;
    checks++;
    if (ifa.rs !== 32'd0 || ifa.rt !== 32'd0) begin
      failures++;
      $display("FAIL zero_reg_bypass: rs=%h rt=%h expected 0", ifa.rs, ifa.rt);
    end
    tick();
    checks++;
    if (ifa.rs !== 32'd0 || ifa.rt !== 32'd0) begin
      failures++;
      $display("FAIL zero_reg_stored: rs=%h rt=%h expected 0", ifa.rs, ifa.rt);
    end
    // Without the zero register, entry 0 behaves like any other.
    ifb.write = 1; ifb.rd_addr = 3'd0; ifb.data_in = 16'hBEEF;
    ifb.rs_addr = 3'd0; ifb.rt_addr = 3'd1;
    tick();
    ifb.write = 0;
    tick();
    checks++;
    if (ifb.rs !== 16'hBEEF || ifb.rt !== exp_rt_b) begin
      failures++;
      $display("FAIL no_zero_reg_b: rs=%h rt=%h expected beef %h", ifb.rs, ifb.rt, exp_rt_b);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      ifa.write   = 1'($urandom_range(0, 1));
      ifa.rd_addr = 6'($urandom_range(0, 15));
      ifa.rs_addr = 6'($urandom_range(0, 15));
      ifa.rt_addr = 6'($urandom_range(0, 15));
      ifa.data_in = $urandom;
      ifb.write   = 1'($urandom_range(0, 1));
      ifb.rd_addr = 3'($urandom_range(0, 7));
      ifb.rs_addr = 3'($urandom_range(0, 7));
      ifb.rt_addr = 3'($urandom_range(0, 7));
      ifb.data_in = 16'($urandom);
      tick();
      checks++;
      if (ifa.rs !== exp_rs_a || ifa.rt !== exp_rt_a || ifa.ready !== 1'b1) begin
        failures++;
        $display("FAIL random_a n=%0d: rs=%h rt=%h ready=%b expected %h %h 1",
                 n, ifa.rs, ifa.rt, ifa.ready, exp_rs_a, exp_rt_a);
      end
      checks++;
      if (ifb.rs !== exp_rs_b || ifb.rt !== exp_rt_b || ifb.ready !== 1'b1) begin
        failures++;
        $display("FAIL random_b n=%0d: rs=%h rt=%h ready=%b expected %h %h 1",
                 n, ifb.rs, ifb.rt, ifb.ready, exp_rs_b, exp_rt_b);
      end
    end
    idle_inputs();
  endtask

  task automatic test_clear_mid();
    int cnt;
    for (int i = 1; i < 64; i++) begin
      ifa.write = 1; ifa.rd_addr = 6'(i); ifa.data_in = 32'(i);
      tick();
    end
    ifa.write = 0; ifa.rs_addr = 6'd7; ifa.rt_addr = 6'd63;
    tick();
    checks++;
    if (ifa.rs !== 32'd7 || ifa.rt !== 32'd63) begin
      failures++;
      $display("FAIL fill_check: rs=%h rt=%h expected 7 3f", ifa.rs, ifa.rt);
    end
    ifa.clear = 1; ifa.write = 1; ifa.rd_addr = 6'd7; ifa.data_in = 32'h777;
    tick();
    ifa.clear = 0; ifa.write = 0;
    checks++;
    if (ifa.ready !== 1'b0) begin
      failures++;
      $display("FAIL clear_ready_fall: ready=%b expected 0", ifa.ready);
    end
    cnt = 0;
    while (ifa.ready !== 1'b1 && cnt < 100) begin
      ifa.clear = (cnt == 10);  // clear during CLEAR must not restart the sweep
      tick();
      cnt++;
      checks++;
      if (ifa.ready !== (busy_a == 0) || ifa.rs !== 32'd0 || ifa.rt !== 32'd0) begin
        failures++;
        $display("FAIL clear_sweep c=%0d: ready=%b rs=%h rt=%h expected %b 0 0",
                 cnt, ifa.ready, ifa.rs, ifa.rt, busy_a == 0);
      end
    end
    ifa.clear = 0;
    checks++;
    if (cnt != 64) begin
      failures++;
      $display("FAIL clear_duration: got %0d expected 64", cnt);
    end
    for (int i = 0; i < 64; i++) begin
      ifa.rs_addr = 6'(i); ifa.rt_addr = 6'(i ^ 7);
      tick();
      checks++;
      if (ifa.rs !== 32'd0 || ifa.rt !== 32'd0) begin
        failures++;
        $display("FAIL after_clear r%0d: rs=%h rt=%h expected 0", i, ifa.rs, ifa.rt);
      end
    end
  endtask

  task automatic test_reset_mid_sweep();
    int cnt;
    ifa.clear = 1; tick(); ifa.clear = 0;
    for (int i = 0; i < 30; i++) tick();
    rst_a = 0; tick(); rst_a = 1;
    cnt = 0;
    while (ifa.ready !== 1'b1 && cnt < 100) begin tick(); cnt++; end
    checks++;
    if (cnt != 64) begin
      failures++;
      $display("FAIL mid_sweep_reset_a: ready after %0d expected 64", cnt);
    end
    ifb.clear = 1; tick(); ifb.clear = 0;
    for (int i = 0; i < 5; i++) tick();
    rst_b = 0; tick(); rst_b = 1;
    cnt = 0;
    while (ifb.ready !== 1'b1 && cnt < 100) begin tick(); cnt++; end
    checks++;
    if (cnt != 8) begin
      failures++;
      $display("FAIL mid_sweep_reset_b: ready after %0d expected 8", cnt);
    end
    for (int i = 0; i < 8; i++) begin
      ifb.rs_addr = 3'(i); ifb.rt_addr = 3'(7 - i);
      tick();
      checks++;
      if (ifb.rs !== 16'd0 || ifb.rt !== 16'd0) begin
        failures++;
        $display("FAIL after_reset_b r%0d: rs=%h rt=%h expected 0", i, ifb.rs, ifb.rt);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem_a[i] = '0;
    for (int i = 0; i < 8; i++) mem_b[i] = '0;
    test_reset();
    test_write_read();
    test_bypass();
    test_zero_reg();
    test_random();
    test_clear_mid();
    test_reset_mid_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
